// File: rtl/juggle_pkg.sv
// Shared widths, slot record and scheduler state encoding for the juggling pipeline.
package juggle_pkg;

  localparam int THROW_W    = 3;
  localparam int BALL_W     = 3;
  localparam int SLOT_DEPTH = 8;
  localparam int MAX_PERIOD = 7;
  localparam int PTR_W      = $clog2(SLOT_DEPTH);

  typedef struct packed {
    logic              v;
    logic [BALL_W-1:0] id;
  } slot_t;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} sched_state_t;

endpackage

// File: rtl/landing_ring.sv
// Landing ring: one slot per future beat holding the ball due to land there.
// Read port is combinational with an optional clear; the write port wins on the same index.
module landing_ring
  import juggle_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              clr,
  input  logic [PTR_W-1:0]  rd_idx,
  input  logic              rd_clr,
  output slot_t             rd_slot,
  input  logic              wr_en,
  input  logic [PTR_W-1:0]  wr_idx,
  input  slot_t             wr_slot,
  output logic              collision,
  output logic [BALL_W-1:0] count
);

  slot_t ring [SLOT_DEPTH];

  // Slot storage: bulk clear, then catch (read-clear) and throw (write).
  always_ff @(posedge clk_in) begin
    if (rst_in || clr) begin
      for (int i = 0; i < SLOT_DEPTH; i++) ring[i] <= '0;
    end else begin
      if (rd_clr) ring[rd_idx] <= '0;
      if (wr_en)  ring[wr_idx] <= wr_slot;
    end
  end

  assign rd_slot   = ring[rd_idx];
  assign collision = wr_en && ring[wr_idx].v;

  // Balls currently airborne; never exceeds 7 since at most 7 balls are ever injected.
  always_comb begin
    count = '0;
    for (int i = 0; i < SLOT_DEPTH; i++)
      count = count + {{(BALL_W-1){1'b0}}, ring[i].v};
  end

endmodule

// File: rtl/throw_scheduler.sv
// Throw scheduler: issues one throw (ball, hand, height) per beat from a latched siteswap.
// Optional checking: define SCHED_ERR_EN to enable the sticky collision / dropped-ball flag.
//
//  state | meaning
//  IDLE  | waiting for a rising edge on pattern_valid_in; beats ignored
//  LOAD  | latch pattern, length, ball count; clear ring and counters
//  RUN   | one throw decision per new_beat; leaves when pattern_valid_in falls
module throw_scheduler
  import juggle_pkg::*;
(
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               new_beat,
  input  logic [THROW_W-1:0] pattern_in [MAX_PERIOD-1:0],
  input  logic [2:0]         pattern_length,
  input  logic [BALL_W-1:0]  num_balls_in,
  input  logic               pattern_valid_in,
  output logic               throw_valid_out,
  output logic [BALL_W-1:0]  throw_ball_out,
  output logic [THROW_W-1:0] throw_height_out,
  output logic               throw_hand_out,
  output logic               running_out,
  output logic [BALL_W-1:0]  balls_air_out,
  output logic               error_out
);

`ifdef SCHED_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  sched_state_t       state_q;
  logic               pv_q;
  logic [THROW_W-1:0] pat_q [MAX_PERIOD-1:0];
  logic [2:0]         len_q;
  logic [BALL_W-1:0]  nb_q;
  logic [PTR_W-1:0]   p_q;
  logic [2:0]         idx_q;
  logic [BALL_W-1:0]  next_ball_q;
  logic               hand_q;

  logic [THROW_W-1:0] h;
  logic               beat;
  logic               ring_clr;
  logic               rd_clr;
  slot_t              rd_slot;
  logic               wr_en;
  logic [PTR_W-1:0]   wr_idx;
  slot_t              wr_slot;
  logic               collision;
  logic [BALL_W-1:0]  ball;
  logic               has_ball;
  logic               inject;
  logic               err_ev;

  assign h        = pat_q[idx_q];
  // A falling pattern_valid_in beats a simultaneous new_beat.
  assign beat     = (state_q == RUN) && new_beat && pattern_valid_in;
  assign ring_clr = (state_q == LOAD) || ((state_q == RUN) && !pattern_valid_in);

  // Ball source for this beat: a landing ball first, else inject a fresh one for a real throw.
  always_comb begin
    rd_clr   = 1'b0;
    ball     = '0;
    has_ball = 1'b0;
    inject   = 1'b0;
    if (beat) begin
      if (rd_slot.v) begin
        ball     = rd_slot.id;
        has_ball = 1'b1;
        rd_clr   = 1'b1;
      end else if ((next_ball_q < nb_q) && (h != '0)) begin
        ball     = next_ball_q;
        has_ball = 1'b1;
        inject   = 1'b1;
      end
    end
  end

  assign wr_en   = beat && has_ball && (h != '0);
  assign wr_idx  = p_q + h;
  assign wr_slot = '{v: 1'b1, id: ball};
  // Collision overwrites the slot; a landing ball with a zero throw is dropped.
  assign err_ev  = ERR_EN && (collision || (beat && rd_slot.v && (h == '0)));

  landing_ring u_ring (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .clr       (ring_clr),
    .rd_idx    (p_q),
    .rd_clr    (rd_clr),
    .rd_slot   (rd_slot),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_slot   (wr_slot),
    .collision (collision),
    .count     (balls_air_out)
  );

  // Sequencing FSM with registered throw outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q          <= IDLE;
      // Track the level through reset so a valid already high is not mistaken for a new edge.
      pv_q             <= pattern_valid_in;
      for (int i = 0; i < MAX_PERIOD; i++) pat_q[i] <= '0;
      len_q            <= '0;
      nb_q             <= '0;
      p_q              <= '0;
      idx_q            <= '0;
      next_ball_q      <= '0;
      hand_q           <= 1'b0;
      throw_valid_out  <= 1'b0;
      throw_ball_out   <= '0;
      throw_height_out <= '0;
      throw_hand_out   <= 1'b0;
      running_out      <= 1'b0;
      error_out        <= 1'b0;
    end else begin
      pv_q            <= pattern_valid_in;
      throw_valid_out <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pattern_valid_in && !pv_q) state_q <= LOAD;
        end
        LOAD: begin
          pat_q       <= pattern_in;
          len_q       <= pattern_length;
          nb_q        <= num_balls_in;
          p_q         <= '0;
          idx_q       <= '0;
          next_ball_q <= '0;
          hand_q      <= 1'b0;
          error_out   <= 1'b0;
          running_out <= 1'b1;
          state_q     <= RUN;
        end
        RUN: begin
          if (!pattern_valid_in) begin
            // error_out stays sticky so a fault can still be read after the pattern stops.
            state_q          <= IDLE;
            running_out      <= 1'b0;
            throw_ball_out   <= '0;
            throw_height_out <= '0;
            throw_hand_out   <= 1'b0;
          end else if (new_beat) begin
            if (wr_en) begin
              throw_valid_out  <= 1'b1;
              throw_ball_out   <= ball;
              throw_height_out <= h;
              throw_hand_out   <= hand_q;
            end
            if (inject) next_ball_q <= next_ball_q + BALL_W'(1);
            if (err_ev) error_out <= 1'b1;
            p_q    <= p_q + PTR_W'(1);
            idx_q  <= (idx_q == len_q - 3'd1) ? 3'd0 : idx_q + 3'd1;
            hand_q <= ~hand_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_throw_scheduler.sv
// Directed bench for throw_scheduler with hand-computed expected throws.
module tb_throw_scheduler;
  import juggle_pkg::*;

  logic               clk_in = 1'b0;
  logic               rst_in;
  logic               new_beat;
  logic [THROW_W-1:0] pattern_in [MAX_PERIOD-1:0];
  logic [2:0]         pattern_length;
  logic [BALL_W-1:0]  num_balls_in;
  logic               pattern_valid_in;
  logic               throw_valid_out;
  logic [BALL_W-1:0]  throw_ball_out;
  logic [THROW_W-1:0] throw_height_out;
  logic               throw_hand_out;
  logic               running_out;
  logic [BALL_W-1:0]  balls_air_out;
  logic               error_out;

  int total = 0;
  int bad   = 0;
  int exp_err;

  always #5 clk_in = ~clk_in;

  throw_scheduler dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .new_beat         (new_beat),
    .pattern_in       (pattern_in),
    .pattern_length   (pattern_length),
    .num_balls_in     (num_balls_in),
    .pattern_valid_in (pattern_valid_in),
    .throw_valid_out  (throw_valid_out),
    .throw_ball_out   (throw_ball_out),
    .throw_height_out (throw_height_out),
    .throw_hand_out   (throw_hand_out),
    .running_out      (running_out),
    .balls_air_out    (balls_air_out),
    .error_out        (error_out)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic beat();
    new_beat = 1'b1;
    tick();
    new_beat = 1'b0;
  endtask

  // Valid throw with ball, height, hand and airborne count.
  task automatic chk_throw(input string tag, input int b, input int h, input int hand, input int air);
    chk({tag, ".valid"}, throw_valid_out, 1);
    chk({tag, ".ball"},  throw_ball_out, b);
    chk({tag, ".h"},     throw_height_out, h);
    chk({tag, ".hand"},  throw_hand_out, hand);
    chk({tag, ".air"},   balls_air_out, air);
  endtask

  task automatic start(input int a0, input int a1, input int a2, input int len, input int nb);
    pattern_valid_in = 1'b0;
    tick();
    tick();
    for (int i = 0; i < MAX_PERIOD; i++) pattern_in[i] = '0;
    pattern_in[0]    = THROW_W'(a0);
    pattern_in[1]    = THROW_W'(a1);
    pattern_in[2]    = THROW_W'(a2);
    pattern_length   = 3'(len);
    num_balls_in     = BALL_W'(nb);
    pattern_valid_in = 1'b1;
    tick();
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".valid"},   throw_valid_out, 0);
    chk({tag, ".ball"},    throw_ball_out, 0);
    chk({tag, ".h"},       throw_height_out, 0);
    chk({tag, ".hand"},    throw_hand_out, 0);
    chk({tag, ".running"}, running_out, 0);
    chk({tag, ".air"},     balls_air_out, 0);
    chk({tag, ".err"},     error_out, 0);
  endtask

  initial begin
    rst_in = 1'b1;
    new_beat = 1'b0;
    pattern_valid_in = 1'b0;
    pattern_length = '0;
    num_balls_in = '0;
    for (int i = 0; i < MAX_PERIOD; i++) pattern_in[i] = '0;
    tick();
    tick();
    rst_in = 1'b0;
    chk_all_zero("reset");

    // 1: cascade {3}, 3 balls
    start(3, 0, 0, 1, 3);
    chk("t1.running", running_out, 1);
    beat(); chk_throw("t1.b0", 0, 3, 0, 1);
    beat(); chk_throw("t1.b1", 1, 3, 1, 2);
    beat(); chk_throw("t1.b2", 2, 3, 0, 3);
    beat(); chk_throw("t1.b3", 0, 3, 1, 3);
    beat(); chk_throw("t1.b4", 1, 3, 0, 3);
    beat(); chk_throw("t1.b5", 2, 3, 1, 3);
    chk("t1.err", error_out, 0);

    // 2: {5,3,1}, 3 balls
    start(5, 3, 1, 3, 3);
    beat(); chk_throw("t2.b0", 0, 5, 0, 1);
    beat(); chk_throw("t2.b1", 1, 3, 1, 2);
    beat(); chk_throw("t2.b2", 2, 1, 0, 3);
    beat(); chk_throw("t2.b3", 2, 5, 1, 3);
    beat(); chk_throw("t2.b4", 1, 3, 0, 3);
    beat(); chk_throw("t2.b5", 0, 1, 1, 3);
    chk("t2.err", error_out, 0);

    // 3: {4,0}, 2 balls: holes on odd beats
    start(4, 0, 0, 2, 2);
    beat(); chk_throw("t3.b0", 0, 4, 0, 1);
    beat(); chk("t3.b1.hole", throw_valid_out, 0);
    beat(); chk_throw("t3.b2", 1, 4, 0, 2);
    beat(); chk("t3.b3.hole", throw_valid_out, 0);
    beat(); chk_throw("t3.b4", 0, 4, 0, 2);
    chk("t3.err", error_out, 0);

    // 4: {3,2,1}, 2 balls: beat1 collides on slot 3, overwrite leaves one ball airborne
    start(3, 2, 1, 3, 2);
    beat(); chk_throw("t4.b0", 0, 3, 0, 1);
    chk("t4.err0", error_out, 0);
    beat(); chk_throw("t4.b1", 1, 2, 1, 1);
`ifdef SCHED_ERR_EN
    exp_err = 1;
`else
    exp_err = 0;
`endif
    chk("t4.err1", error_out, exp_err);

    // 5: fall of valid together with a beat
    start(3, 0, 0, 1, 3);
    beat(); beat();
    chk("t5.air2", balls_air_out, 2);
    pattern_valid_in = 1'b0;
    new_beat = 1'b1;
    tick();
    new_beat = 1'b0;
    chk("t5.fall.valid", throw_valid_out, 0);
    chk("t5.fall.running", running_out, 0);
    chk("t5.fall.air", balls_air_out, 0);
    beat();
    chk("t5.idle.beat", throw_valid_out, 0);
    pattern_valid_in = 1'b1;
    tick();
    tick();
    chk("t5.rerun.running", running_out, 1);
    beat(); chk_throw("t5.rerun.b0", 0, 3, 0, 1);

    // 6: reset mid-beat, beats ignored until a fresh rising edge
    start(3, 0, 0, 1, 3);
    beat(); beat();
    rst_in = 1'b1;
    new_beat = 1'b1;
    tick();
    rst_in = 1'b0;
    new_beat = 1'b0;
    chk_all_zero("t6.rst");
    tick();
    beat();
    chk("t6.ign.valid", throw_valid_out, 0);
    chk("t6.ign.running", running_out, 0);
    beat();
    chk("t6.ign2.valid", throw_valid_out, 0);
    pattern_valid_in = 1'b0;
    tick();
    pattern_valid_in = 1'b1;
    tick();
    tick();
    chk("t6.rerun.running", running_out, 1);
    beat(); chk_throw("t6.rerun.b0", 0, 3, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
